// File: rtl/rvfi_trace_buffer.sv
// rvfi_trace_buffer
//   On-chip capture of the RVFI retirement stream into a circular buffer,
//   gated by an arm / trigger / post-trigger state machine and drained
//   through a valid/ready readout port.
//
// State table
//   state   | meaning
//   IDLE    | no session, nothing captured
//   ARMED   | waiting for the trigger retirement
//   CAPTURE | recording every retirement after the trigger
//   DONE    | post-trigger quota reached, capture stopped
//
// Ports
//   clk, rst_n                 clock, async active-low reset
//   arm_i, disarm_i, flush_i   session control pulses
//   trig_en_i, trig_pc_i       trigger select and pc
//   rvfi_*                     retirement stream from the core
//   rd_valid_o, rd_ready_i     readout handshake
//   rd_*_o, rd_trig_o          head record fields (zero when empty)
//   count_o, drop_cnt_o        occupancy, lost-record counter
//   state_o                    IDLE=0 ARMED=1 CAPTURE=2 DONE=3
module rvfi_trace_buffer #(
  parameter int DEPTH     = 16,
  parameter int OVERWRITE = 0,
  parameter int POST_TRIG = 8,
  parameter int DROP_W    = 16
) (
  input  logic                       clk,
  input  logic                       rst_n,
  input  logic                       arm_i,
  input  logic                       disarm_i,
  input  logic                       flush_i,
  input  logic                       trig_en_i,
  input  logic [31:0]                trig_pc_i,
  input  logic                       rvfi_valid,
  input  logic [31:0]                rvfi_pc_rdata,
  input  logic [4:0]                 rvfi_rd_addr,
  input  logic [31:0]                rvfi_rd_wdata,
  input  logic [31:0]                rvfi_mem_addr,
  input  logic [3:0]                 rvfi_mem_rmask,
  input  logic [3:0]                 rvfi_mem_wmask,
  output logic                       rd_valid_o,
  input  logic                       rd_ready_i,
  output logic [31:0]                rd_pc_o,
  output logic [4:0]                 rd_rd_addr_o,
  output logic [31:0]                rd_rd_wdata_o,
  output logic [31:0]                rd_mem_addr_o,
  output logic [3:0]                 rd_mem_rmask_o,
  output logic [3:0]                 rd_mem_wmask_o,
  output logic                       rd_trig_o,
  output logic [$clog2(DEPTH+1)-1:0] count_o,
  output logic [DROP_W-1:0]          drop_cnt_o,
  output logic [1:0]                 state_o
);

  localparam int AW = $clog2(DEPTH);
  localparam int CW = $clog2(DEPTH+1);
  localparam int PW = $clog2(POST_TRIG+2);
  localparam int RW = 1 + 32 + 5 + 32 + 32 + 4 + 4;

  localparam logic [1:0] S_IDLE    = 2'd0;
  localparam logic [1:0] S_ARMED   = 2'd1;
  localparam logic [1:0] S_CAPTURE = 2'd2;
  localparam logic [1:0] S_DONE    = 2'd3;

  logic [1:0]    state;
  logic [PW-1:0] post_cnt;
  logic [PW-1:0] post_nxt;
  logic [AW-1:0] wptr, rptr;
  logic [CW-1:0] count;
  logic [DROP_W-1:0] drop_cnt;
  logic [RW-1:0] mem [DEPTH];
  logic [RW-1:0] wr_rec, head;

  logic trig_hit, push_req, pop, full, do_write, drop_evt, adv_r;

  assign trig_hit = rvfi_valid && (trig_en_i ? (rvfi_pc_rdata == trig_pc_i) : 1'b1);
  // A retirement is recorded on the trigger itself and on every
  // retirement while capturing; disarm suppresses the same-cycle record.
  assign push_req = !disarm_i &&
                    ((state == S_ARMED && trig_hit) || (state == S_CAPTURE && rvfi_valid));
  assign pop      = rd_valid_o && rd_ready_i;
  assign full     = (count == CW'(DEPTH));
  assign drop_evt = push_req && full && !pop;
  assign do_write = push_req && (!full || pop || (OVERWRITE != 0));
  // Overwrite on a full buffer retires the oldest entry in place of a pop.
  assign adv_r    = pop || ((OVERWRITE != 0) && drop_evt);
  assign post_nxt = post_cnt + PW'(1);

  assign wr_rec = {(state == S_ARMED), rvfi_pc_rdata, rvfi_rd_addr, rvfi_rd_wdata,
                   rvfi_mem_addr, rvfi_mem_rmask, rvfi_mem_wmask};

  always_ff @(posedge clk) begin
    if (do_write && !flush_i) mem[wptr] <= wr_rec;
  end

  // Storage is not reset, so fields are masked while the buffer is empty.
  assign head = rd_valid_o ? mem[rptr] : '0;
  assign {rd_trig_o, rd_pc_o, rd_rd_addr_o, rd_rd_wdata_o,
          rd_mem_addr_o, rd_mem_rmask_o, rd_mem_wmask_o} = head;

  assign rd_valid_o = (count != '0);
  assign count_o    = count;
  assign drop_cnt_o = drop_cnt;
  assign state_o    = state;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wptr     <= '0;
      rptr     <= '0;
      count    <= '0;
      drop_cnt <= '0;
    end else if (flush_i) begin
      wptr     <= '0;
      rptr     <= '0;
      count    <= '0;
      drop_cnt <= '0;
    end else begin
      if (do_write) wptr <= wptr + AW'(1);
      if (adv_r)    rptr <= rptr + AW'(1);
      count <= count + CW'(do_write) - CW'(adv_r);
      if (drop_evt && (drop_cnt != '1)) drop_cnt <= drop_cnt + DROP_W'(1);
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state    <= S_IDLE;
      post_cnt <= '0;
    end else if (disarm_i) begin
      state    <= S_IDLE;
      post_cnt <= '0;
    end else begin
      case (state)
        S_IDLE: if (arm_i) state <= S_ARMED;
        S_ARMED: begin
          if (trig_hit) begin
            post_cnt <= PW'(1);
            state    <= (POST_TRIG == 1) ? S_DONE : S_CAPTURE;
          end
        end
        S_CAPTURE: begin
          // POST_TRIG == 0 means capture until disarm; the counter is idle.
          if (rvfi_valid && (POST_TRIG != 0)) begin
            post_cnt <= post_nxt;
            if (post_nxt == PW'(POST_TRIG)) state <= S_DONE;
          end
        end
        default: if (arm_i) state <= S_ARMED;
      endcase
    end
  end

endmodule

// File: tb/tb_rvfi_trace_buffer.sv
// Testbench for rvfi_trace_buffer: three instances share the input stimulus.
//   a: DEPTH=16, OVERWRITE=0, POST_TRIG=4
//   b: DEPTH=4,  OVERWRITE=0, POST_TRIG=0
//   c: DEPTH=4,  OVERWRITE=1, POST_TRIG=0
module tb_rvfi_trace_buffer;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        arm_i = 1'b0, disarm_i = 1'b0, flush_i = 1'b0;
  logic        trig_en_i = 1'b0;
  logic [31:0] trig_pc_i = '0;
  logic        rvfi_valid = 1'b0;
  logic [31:0] rvfi_pc_rdata = '0, rvfi_rd_wdata = '0, rvfi_mem_addr = '0;
  logic [4:0]  rvfi_rd_addr = '0;
  logic [3:0]  rvfi_mem_rmask = '0, rvfi_mem_wmask = '0;
  logic        rd_ready_i = 1'b0;

  int n_checks = 0;
  int n_fail = 0;

  always #5 clk = ~clk;

  logic        a_valid, b_valid, c_valid, a_trig, b_trig, c_trig;
  logic [31:0] a_pc, b_pc, c_pc, a_wd, b_wd, c_wd, a_ma, b_ma, c_ma;
  logic [4:0]  a_ra, b_ra, c_ra;
  logic [3:0]  a_rm, b_rm, c_rm, a_wm, b_wm, c_wm;
  logic [4:0]  a_count;
  logic [2:0]  b_count, c_count;
  logic [15:0] a_drop, b_drop, c_drop;
  logic [1:0]  a_state, b_state, c_state;

  rvfi_trace_buffer #(.DEPTH(16), .OVERWRITE(0), .POST_TRIG(4), .DROP_W(16)) dut_a (
    .clk(clk), .rst_n(rst_n), .arm_i(arm_i), .disarm_i(disarm_i), .flush_i(flush_i),
    .trig_en_i(trig_en_i), .trig_pc_i(trig_pc_i), .rvfi_valid(rvfi_valid),
    .rvfi_pc_rdata(rvfi_pc_rdata), .rvfi_rd_addr(rvfi_rd_addr), .rvfi_rd_wdata(rvfi_rd_wdata),
    .rvfi_mem_addr(rvfi_mem_addr), .rvfi_mem_rmask(rvfi_mem_rmask), .rvfi_mem_wmask(rvfi_mem_wmask),
    .rd_valid_o(a_valid), .rd_ready_i(rd_ready_i), .rd_pc_o(a_pc), .rd_rd_addr_o(a_ra),
    .rd_rd_wdata_o(a_wd), .rd_mem_addr_o(a_ma), .rd_mem_rmask_o(a_rm), .rd_mem_wmask_o(a_wm),
    .rd_trig_o(a_trig), .count_o(a_count), .drop_cnt_o(a_drop), .state_o(a_state));

  rvfi_trace_buffer #(.DEPTH(4), .OVERWRITE(0), .POST_TRIG(0), .DROP_W(16)) dut_b (
    .clk(clk), .rst_n(rst_n), .arm_i(arm_i), .disarm_i(disarm_i), .flush_i(flush_i),
    .trig_en_i(trig_en_i), .trig_pc_i(trig_pc_i), .rvfi_valid(rvfi_valid),
    .rvfi_pc_rdata(rvfi_pc_rdata), .rvfi_rd_addr(rvfi_rd_addr), .rvfi_rd_wdata(rvfi_rd_wdata),
    .rvfi_mem_addr(rvfi_mem_addr), .rvfi_mem_rmask(rvfi_mem_rmask), .rvfi_mem_wmask(rvfi_mem_wmask),
    .rd_valid_o(b_valid), .rd_ready_i(rd_ready_i), .rd_pc_o(b_pc), .rd_rd_addr_o(b_ra),
    .rd_rd_wdata_o(b_wd), .rd_mem_addr_o(b_ma), .rd_mem_rmask_o(b_rm), .rd_mem_wmask_o(b_wm),
    .rd_trig_o(b_trig), .count_o(b_count), .drop_cnt_o(b_drop), .state_o(b_state));

  rvfi_trace_buffer #(.DEPTH(4), .OVERWRITE(1), .POST_TRIG(0), .DROP_W(16)) dut_c (
    .clk(clk), .rst_n(rst_n), .arm_i(arm_i), .disarm_i(disarm_i), .flush_i(flush_i),
    .trig_en_i(trig_en_i), .trig_pc_i(trig_pc_i), .rvfi_valid(rvfi_valid),
    .rvfi_pc_rdata(rvfi_pc_rdata), .rvfi_rd_addr(rvfi_rd_addr), .rvfi_rd_wdata(rvfi_rd_wdata),
    .rvfi_mem_addr(rvfi_mem_addr), .rvfi_mem_rmask(rvfi_mem_rmask), .rvfi_mem_wmask(rvfi_mem_wmask),
    .rd_valid_o(c_valid), .rd_ready_i(rd_ready_i), .rd_pc_o(c_pc), .rd_rd_addr_o(c_ra),
    .rd_rd_wdata_o(c_wd), .rd_mem_addr_o(c_ma), .rd_mem_rmask_o(c_rm), .rd_mem_wmask_o(c_wm),
    .rd_trig_o(c_trig), .count_o(c_count), .drop_cnt_o(c_drop), .state_o(c_state));

  // Inputs change 1 time unit after the rising edge; outputs are sampled there too.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic set_ret(input logic [31:0] pc);
    rvfi_valid     = 1'b1;
    rvfi_pc_rdata  = pc;
    rvfi_rd_wdata  = ~pc;
    rvfi_rd_addr   = pc[6:2];
    rvfi_mem_addr  = pc ^ 32'hA5A5_0000;
    rvfi_mem_rmask = pc[5:2];
    rvfi_mem_wmask = ~pc[5:2];
  endtask

  task automatic retire(input logic [31:0] pc);
    set_ret(pc);
    tick();
    rvfi_valid = 1'b0;
  endtask

  task automatic pulse_arm();    arm_i = 1'b1;    tick(); arm_i = 1'b0;    endtask
  task automatic pulse_disarm(); disarm_i = 1'b1; tick(); disarm_i = 1'b0; endtask
  task automatic pulse_flush();  flush_i = 1'b1;  tick(); flush_i = 1'b0;  endtask

  task automatic test_reset();
    #2;
    n_checks++; if (a_state !== 2'd0) begin n_fail++; $display("FAIL reset_state_a got %0d want 0", a_state); end
    n_checks++; if (a_count !== 5'd0) begin n_fail++; $display("FAIL reset_count_a got %0d want 0", a_count); end
    n_checks++; if (a_valid !== 1'b0) begin n_fail++; $display("FAIL reset_valid_a got %0b want 0", a_valid); end
    n_checks++; if (a_drop !== 16'd0) begin n_fail++; $display("FAIL reset_drop_a got %0d want 0", a_drop); end
    n_checks++; if ({a_pc, a_wd, a_ma, a_ra, a_rm, a_wm, a_trig} !== '0) begin
      n_fail++; $display("FAIL reset_data_a got pc %h want 0", a_pc); end
    n_checks++; if ({b_state, b_count, c_state, c_count} !== '0) begin
      n_fail++; $display("FAIL reset_bc got %h want 0", {b_state, b_count, c_state, c_count}); end
    @(negedge clk);
    rst_n = 1'b1;
    tick();
  endtask

  task automatic test_trigger();
    logic [31:0] pcs [7];
    pcs = '{32'hF8, 32'hFC, 32'h100, 32'h104, 32'h108, 32'h10C, 32'h110};
    trig_en_i = 1'b1;
    trig_pc_i = 32'h0000_0100;
    pulse_arm();
    n_checks++; if (a_state !== 2'd1) begin n_fail++; $display("FAIL arm_state got %0d want 1", a_state); end
    retire(pcs[0]);
    retire(pcs[1]);
    n_checks++; if (a_state !== 2'd1 || a_count !== 5'd0) begin
      n_fail++; $display("FAIL pre_trig got state %0d count %0d want 1 0", a_state, a_count); end
    retire(pcs[2]);
    n_checks++; if (a_state !== 2'd2 || a_count !== 5'd1) begin
      n_fail++; $display("FAIL on_trig got state %0d count %0d want 2 1", a_state, a_count); end
    for (int i = 3; i < 7; i++) retire(pcs[i]);
    n_checks++; if (a_state !== 2'd3) begin n_fail++; $display("FAIL trig_done got %0d want 3", a_state); end
    n_checks++; if (a_count !== 5'd4) begin n_fail++; $display("FAIL trig_count got %0d want 4", a_count); end
    n_checks++; if (b_drop !== 16'd1 || b_pc !== 32'h100) begin
      n_fail++; $display("FAIL trig_b got drop %0d pc %h want 1 100", b_drop, b_pc); end
    n_checks++; if (c_drop !== 16'd1 || c_pc !== 32'h104) begin
      n_fail++; $display("FAIL trig_c got drop %0d pc %h want 1 104", c_drop, c_pc); end
    rd_ready_i = 1'b1;
    for (int i = 0; i < 4; i++) begin
      logic [31:0] epc;
      epc = 32'h100 + 32'(4 * i);
      n_checks++; if (a_pc !== epc || a_trig !== (i == 0)) begin
        n_fail++; $display("FAIL trig_rec%0d got pc %h trig %0b want %h %0b", i, a_pc, a_trig, epc, (i == 0)); end
      n_checks++; if (a_wd !== ~epc || a_ra !== epc[6:2] || a_ma !== (epc ^ 32'hA5A5_0000)
                      || a_rm !== epc[5:2] || a_wm !== ~epc[5:2]) begin
        n_fail++; $display("FAIL trig_fields%0d got wd %h ma %h want %h %h", i, a_wd, a_ma, ~epc, epc ^ 32'hA5A5_0000); end
      tick();
    end
    rd_ready_i = 1'b0;
    n_checks++; if (a_count !== 5'd0 || a_valid !== 1'b0 || a_state !== 2'd3) begin
      n_fail++; $display("FAIL trig_drained got count %0d valid %0b state %0d want 0 0 3", a_count, a_valid, a_state); end
  endtask

  task automatic test_overflow();
    pulse_disarm();
    pulse_flush();
    trig_en_i = 1'b0;
    pulse_arm();
    for (int i = 0; i < 6; i++) retire(32'h1000 + 32'(4 * i));
    n_checks++; if (b_count !== 3'd4 || b_drop !== 16'd2 || b_pc !== 32'h1000) begin
      n_fail++; $display("FAIL ovf_drop got count %0d drop %0d pc %h want 4 2 1000", b_count, b_drop, b_pc); end
    n_checks++; if (c_count !== 3'd4 || c_drop !== 16'd2 || c_pc !== 32'h1008) begin
      n_fail++; $display("FAIL ovf_over got count %0d drop %0d pc %h want 4 2 1008", c_count, c_drop, c_pc); end
    n_checks++; if (b_state !== 2'd2 || c_state !== 2'd2) begin
      n_fail++; $display("FAIL ovf_state got %0d %0d want 2 2", b_state, c_state); end
    rd_ready_i = 1'b1;
    for (int i = 0; i < 4; i++) begin
      n_checks++; if (b_pc !== 32'h1000 + 32'(4 * i) || c_pc !== 32'h1008 + 32'(4 * i)) begin
        n_fail++; $display("FAIL ovf_drain%0d got %h %h want %h %h", i, b_pc, c_pc,
                           32'h1000 + 32'(4 * i), 32'h1008 + 32'(4 * i)); end
      tick();
    end
    rd_ready_i = 1'b0;
    n_checks++; if (b_count !== 3'd0 || c_count !== 3'd0 || c_valid !== 1'b0) begin
      n_fail++; $display("FAIL ovf_empty got %0d %0d want 0 0", b_count, c_count); end
  endtask

  task automatic test_back_to_back();
    pulse_flush();
    for (int i = 0; i < 4; i++) retire(32'h2000 + 32'(4 * i));
    n_checks++; if (b_count !== 3'd4 || c_count !== 3'd4) begin
      n_fail++; $display("FAIL b2b_fill got %0d %0d want 4 4", b_count, c_count); end
    rd_ready_i = 1'b1;
    for (int i = 0; i < 10; i++) begin
      set_ret(32'h2010 + 32'(4 * i));
      n_checks++; if (b_pc !== 32'h2000 + 32'(4 * i) || c_pc !== 32'h2000 + 32'(4 * i)
                      || b_count !== 3'd4 || c_count !== 3'd4) begin
        n_fail++; $display("FAIL b2b_cyc%0d got %h %h cnt %0d %0d want %h 4", i, b_pc, c_pc,
                           b_count, c_count, 32'h2000 + 32'(4 * i)); end
      tick();
    end
    rvfi_valid = 1'b0;
    rd_ready_i = 1'b0;
    n_checks++; if (b_drop !== 16'd0 || c_drop !== 16'd0 || b_count !== 3'd4 || c_pc !== 32'h2028) begin
      n_fail++; $display("FAIL b2b_end got drop %0d %0d count %0d pc %h want 0 0 4 2028", b_drop, c_drop, b_count, c_pc); end
  endtask

  task automatic test_flush();
    flush_i = 1'b1;
    rd_ready_i = 1'b1;
    set_ret(32'h3000);
    tick();
    flush_i = 1'b0;
    rd_ready_i = 1'b0;
    rvfi_valid = 1'b0;
    n_checks++; if (b_count !== 3'd0 || b_valid !== 1'b0 || b_drop !== 16'd0 || b_state !== 2'd2) begin
      n_fail++; $display("FAIL flush_b got count %0d valid %0b drop %0d state %0d want 0 0 0 2", b_count, b_valid, b_drop, b_state); end
    n_checks++; if (c_count !== 3'd0 || c_drop !== 16'd0 || c_state !== 2'd2) begin
      n_fail++; $display("FAIL flush_c got count %0d drop %0d state %0d want 0 0 2", c_count, c_drop, c_state); end
    arm_i = 1'b1;
    disarm_i = 1'b1;
    tick();
    arm_i = 1'b0;
    disarm_i = 1'b0;
    n_checks++; if (a_state !== 2'd0 || b_state !== 2'd0 || c_state !== 2'd0) begin
      n_fail++; $display("FAIL disarm_wins got %0d %0d %0d want 0 0 0", a_state, b_state, c_state); end
  endtask

  task automatic test_reset_mid();
    pulse_flush();
    trig_en_i = 1'b0;
    pulse_arm();
    for (int i = 0; i < 4; i++) retire(32'h4000 + 32'(4 * i));
    pulse_arm();
    retire(32'h4010);
    n_checks++; if (a_state !== 2'd2 || a_count !== 5'd5) begin
      n_fail++; $display("FAIL mid_setup got state %0d count %0d want 2 5", a_state, a_count); end
    n_checks++; if (b_drop !== 16'd1) begin n_fail++; $display("FAIL mid_bdrop got %0d want 1", b_drop); end
    #3;
    rst_n = 1'b0;
    #1;
    n_checks++; if (a_state !== 2'd0 || a_count !== 5'd0 || a_valid !== 1'b0 || a_drop !== 16'd0) begin
      n_fail++; $display("FAIL mid_reset_a got state %0d count %0d valid %0b drop %0d want 0", a_state, a_count, a_valid, a_drop); end
    n_checks++; if (b_drop !== 16'd0 || b_state !== 2'd0 || b_pc !== 32'd0) begin
      n_fail++; $display("FAIL mid_reset_b got drop %0d state %0d pc %h want 0", b_drop, b_state, b_pc); end
    @(negedge clk);
    rst_n = 1'b1;
    tick();
  endtask

  initial begin
    test_reset();
    test_trigger();
    test_overflow();
    test_back_to_back();
    test_flush();
    test_reset_mid();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/rvfi_trace_buffer.md
# rvfi_trace_buffer

Synthesizable, parametrised on-chip trace capture for the RVFI retirement stream. Records retired instructions (pc, rd write, first memory access) into a circular buffer under control of an arm/trigger/post-trigger state machine, and drains records through a valid/ready readout port. Sits beside the core on the RVFI outputs, usable in FPGA/emulation where file-based simulation tracing is unavailable.

## Interface
- DEPTH, 16, buffer entries; power of two, 2..256.
- OVERWRITE, 0, full policy: 0 = drop new record, 1 = overwrite oldest.
- POST_TRIG, 8, records written from trigger (inclusive) before stopping; 0 = capture until disarm.
- DROP_W, 16, width of saturating drop counter.
- clk  in  1  clock.
- rst_n  in  1  asynchronous active-low reset.
- arm_i  in  1  pulse: start a capture session.
- disarm_i  in  1  pulse: abort session, return to IDLE.
- flush_i  in  1  pulse: empty buffer, clear drop counter.
- trig_en_i  in  1  1 = trigger on pc match; 0 = trigger on first retirement after arm.
- trig_pc_i  in  32  trigger pc.
- rvfi_valid  in  1  retirement strobe.
- rvfi_pc_rdata  in  32  retired pc.
- rvfi_rd_addr  in  5  destination register.
- rvfi_rd_wdata  in  32  destination write data.
- rvfi_mem_addr  in  32  memory address (lower channel only).
- rvfi_mem_rmask  in  4  read mask.
- rvfi_mem_wmask  in  4  write mask.
- rd_valid_o  out  1  record available.
- rd_ready_i  in  1  consumer accepts record.
- rd_pc_o, rd_rd_addr_o, rd_rd_wdata_o, rd_mem_addr_o, rd_mem_rmask_o, rd_mem_wmask_o  out  32/5/32/32/4/4  head record fields.
- rd_trig_o  out  1  head record is the trigger record.
- count_o  out  $clog2(DEPTH+1)  occupancy.
- drop_cnt_o  out  DROP_W  records lost (dropped or overwritten).
- state_o  out  2  IDLE=0, ARMED=1, CAPTURE=2, DONE=3.

## Operation
- Clock/reset as decided: single clk; rst_n asynchronous, active-low. Reset: state IDLE, pointers 0, count_o 0, rd_valid_o 0, drop_cnt_o 0, all rd_* data outputs 0, post counter 0.
- IDLE: no capture. arm_i -> ARMED. arm_i does not flush.
- ARMED: no capture. Trigger retirement = rvfi_valid && (trig_en_i ? rvfi_pc_rdata == trig_pc_i : 1). Trigger record is written with trig flag set; -> CAPTURE, post counter = 1. If POST_TRIG == 1 -> DONE directly.
- CAPTURE: every rvfi_valid writes one record (trig flag 0), post counter +1; when post counter reaches POST_TRIG -> DONE. POST_TRIG == 0: counter unused, stays in CAPTURE.
- DONE: no capture. arm_i -> ARMED (new session, buffer kept).
- disarm_i in any state -> IDLE; same-cycle retirement not written. disarm_i beats arm_i.
- arm_i in ARMED/CAPTURE ignored.
- Post counter advances on every eligible retirement, whether the record is stored or dropped.
- Full, OVERWRITE=0, no pop: record discarded, drop_cnt_o +1. Full with simultaneous pop: push accepted, count unchanged.
- Full, OVERWRITE=1, no pop: oldest record discarded (read pointer advances), new written, drop_cnt_o +1; head data may change while rd_valid_o is held — consumer tolerates this in overwrite mode only. With simultaneous pop: normal push+pop, no drop.
- drop_cnt_o saturates at all-ones.
- flush_i: pointers and count to 0, drop_cnt_o to 0; same-cycle push and pop discarded (not counted as drop). State unaffected.
- Pointers wrap modulo DEPTH.

## Timing
- Write at rising edge of the retirement cycle; record visible (rd_valid_o, rd_* fields, count_o) the following cycle.
- rd_valid_o = (count_o != 0); rd_* driven combinationally from storage at read pointer.
- Pop when rd_valid_o && rd_ready_i; next head visible next cycle. rd_ready_i without rd_valid_o has no effect.
- State transitions take effect the cycle after the causing input; state_o registered.
- Throughput: one record per cycle in, one per cycle out, sustained.

## Test plan
- Reset mid-capture (rst_n low with count 5, CAPTURE) -> state_o 0, count_o 0, rd_valid_o 0, drop_cnt_o 0 immediately, asynchronously.
- trig_en_i=1, trig_pc_i=0x0000_0100, POST_TRIG=4, retire pcs 0xF8,0xFC,0x100,0x104,0x108,0x10C,0x110 -> four records 0x100..0x10C stored, only first has rd_trig_o=1, state_o=3, 0x110 not stored.
- OVERWRITE=0, DEPTH=4, POST_TRIG=0, 6 retirements, rd_ready_i=0 -> count_o 4, drop_cnt_o 2, head pc = first retired.
- OVERWRITE=1, same stimulus -> count_o 4, drop_cnt_o 2, head pc = third retired; drain yields retirements 3..6 in order.
- Full buffer, simultaneous rvfi_valid and pop every cycle for 10 cycles -> count_o stays 4, drop_cnt_o 0, records emerge in order.
- flush_i coincident with rvfi_valid and pop -> count_o 0, drop_cnt_o 0, state unchanged; disarm_i with arm_i -> state_o 0.
